// File: rtl/dsp_pkg.sv
// ---------------------------------------------------------------------------
// dsp_pkg
// Shared definitions for the dsp_mac_pipe multiply-accumulate datapath.
//   - op encodings for the per-sample operation select
//   - mac_latency(): input-to-output latency in clock cycles
//   - sat_max()/sat_min(): saturation limits for a signed result of a given
//     width (returned right-aligned in 128 bits; the caller casts the value
//     down to its own width)
// ---------------------------------------------------------------------------
package dsp_pkg;

    localparam logic [1:0] OP_MUL    = 2'd0; // P = A*B
    localparam logic [1:0] OP_MULADD = 2'd1; // P = A*B + C
    localparam logic [1:0] OP_MACC   = 2'd2; // P = P_acc + A*B
    localparam logic [1:0] OP_CSUB   = 2'd3; // P = C - A*B

    // Input register stages, optional product register, then the final
    // accumulator register.
    function automatic int mac_latency(input int in_regs, input int mreg);
        return in_regs + mreg + 1;
    endfunction

    // Largest positive value of a w-bit signed number.
    function automatic logic [127:0] sat_max(input int w);
        return (128'd1 << (w - 1)) - 128'd1;
    endfunction

    // Most negative value of a w-bit signed number (low w bits are 10..0).
    function automatic logic [127:0] sat_min(input int w);
        return 128'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/dsp_delay_line.sv
// ---------------------------------------------------------------------------
// dsp_delay_line
// Fixed-depth shift register with asynchronous active-high reset. Every
// stage clears to zero on reset and shifts on every clock otherwise.
// Ports:
//   clk   in   clock
//   rst   in   asynchronous, active-high reset
//   din   in   W   data entering the first stage
//   dout  out  W   data leaving the last stage (DEPTH cycles later)
// DEPTH must be at least 1.
// ---------------------------------------------------------------------------
module dsp_delay_line #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/dsp_mac_pipe.sv
// ---------------------------------------------------------------------------
// dsp_mac_pipe
// Signed multiply-accumulate pipeline with a valid-only handshake (no
// back-pressure). Each valid sample produces exactly one result,
// IN_REGS + MREG + 1 cycles later, in issue order.
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous, active-high reset
//   in_valid   in   sample valid; a/b/c/op/acc_clr are used only when high
//   a          in   A_W  signed operand A
//   b          in   B_W  signed operand B
//   c          in   P_W  signed addend C
//   op         in   2    0: A*B  1: A*B+C  2: P_acc+A*B  3: C-A*B
//   acc_clr    in   with op=2 the accumulator reads as 0; always clears ovf
//   out_valid  out  p holds a new result this cycle
//   p          out  P_W  signed result / accumulator (holds between results)
//   ovf        out  sticky overflow since reset or the last acc_clr
//
// Handshake: out_valid is a one-cycle pulse per accepted sample; there is
// no ready, so the consumer must take the result in the cycle it appears.
//
// Optional feature: define DSP_MAC_SAT_EN to saturate p on overflow instead
// of wrapping. ovf sets in both builds.
// ---------------------------------------------------------------------------
module dsp_mac_pipe
    import dsp_pkg::*;
#(
    parameter int A_W     = 30,
    parameter int B_W     = 18,
    parameter int P_W     = 48,
    parameter int IN_REGS = 1,
    parameter int MREG    = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    input  logic [P_W-1:0] c,
    input  logic [1:0]     op,
    input  logic           acc_clr,
    output logic           out_valid,
    output logic [P_W-1:0] p,
    output logic           ovf
);

    localparam int LAT   = mac_latency(IN_REGS, MREG);
    localparam int M_W   = A_W + B_W;
    localparam int BUS_W = M_W + P_W + 3;

    if (P_W < A_W + B_W) begin : g_pw_check
        $error("dsp_mac_pipe: P_W must be >= A_W + B_W");
    end
    if (IN_REGS < 1 || IN_REGS > 2) begin : g_inregs_check
        $error("dsp_mac_pipe: IN_REGS must be 1 or 2");
    end
    if (MREG < 0 || MREG > 1) begin : g_mreg_check
        $error("dsp_mac_pipe: MREG must be 0 or 1");
    end

    // ---------------- input register stages ----------------
    // Bus layout: {a, b, c, op, acc_clr}
    logic [BUS_W-1:0] in_q;

    dsp_delay_line #(.W(BUS_W), .DEPTH(IN_REGS)) u_in_regs (
        .clk  (clk),
        .rst  (rst),
        .din  ({a, b, c, op, acc_clr}),
        .dout (in_q)
    );

    logic signed [A_W-1:0] a_q;
    logic signed [B_W-1:0] b_q;
    logic signed [M_W-1:0] prod;

    assign a_q  = in_q[BUS_W-1 -: A_W];
    assign b_q  = in_q[BUS_W-1-A_W -: B_W];
    // Full-width signed product; exact for every operand pair including
    // the most-negative * most-negative corner.
    assign prod = a_q * b_q;

    // ---------------- optional product register ----------------
    // Bus layout: {prod, c, op, acc_clr}
    logic [BUS_W-1:0] m_d;
    logic [BUS_W-1:0] m_q;

    assign m_d = {prod, in_q[P_W+2:0]};

    if (MREG == 1) begin : g_mreg
        dsp_delay_line #(.W(BUS_W), .DEPTH(1)) u_m_reg (
            .clk  (clk),
            .rst  (rst),
            .din  (m_d),
            .dout (m_q)
        );
    end else begin : g_no_mreg
        assign m_q = m_d;
    end

    logic signed [M_W-1:0] prod_m;
    logic        [P_W-1:0] c_m;
    logic        [1:0]     op_m;
    logic                  clr_m;

    assign prod_m = m_q[BUS_W-1 -: M_W];
    assign c_m    = m_q[P_W+2:3];
    assign op_m   = m_q[2:1];
    assign clr_m  = m_q[0];

    // ---------------- valid pipe ----------------
    // Runs alongside the data up to the final register.
    logic v_m;

    dsp_delay_line #(.W(1), .DEPTH(LAT-1)) u_vld (
        .clk  (clk),
        .rst  (rst),
        .din  (in_valid),
        .dout (v_m)
    );

    // ---------------- final add / accumulate stage ----------------
    logic signed [P_W-1:0] prod_ext;
    logic        [P_W-1:0] base;
    logic                  neg;
    logic        [P_W:0]   lhs;
    logic        [P_W:0]   rhs;
    logic        [P_W:0]   sum;
    logic                  of;
    logic        [P_W-1:0] res;

    assign prod_ext = P_W'(prod_m);

`ifdef DSP_MAC_SAT_EN
    localparam logic [P_W-1:0] SAT_MAX = P_W'(sat_max(P_W));
    localparam logic [P_W-1:0] SAT_MIN = P_W'(sat_min(P_W));
`endif

    always_comb begin
        base = '0;
        neg  = 1'b0;
        case (op_m)
            OP_MUL:    base = '0;
            OP_MULADD: base = c_m;
            OP_MACC:   base = clr_m ? '0 : p;  // 1-cycle feedback from p
            OP_CSUB: begin
                base = c_m;
                neg  = 1'b1;
            end
            default:   base = '0;
        endcase

        // One guard bit: the true result always fits in P_W+1 bits.
        lhs = {base[P_W-1], base};
        rhs = {prod_ext[P_W-1], prod_ext};
        sum = neg ? (lhs - rhs) : (lhs + rhs);
        of  = sum[P_W] ^ sum[P_W-1];

`ifdef DSP_MAC_SAT_EN
        // Guard bit carries the sign of the true sum.
        if (of) begin
            res = sum[P_W] ? SAT_MIN : SAT_MAX;
        end else begin
            res = sum[P_W-1:0];
        end
`else
        res = sum[P_W-1:0];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            p         <= '0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= v_m;
            if (v_m) begin
                p   <= res;
                // acc_clr drops the history; this sample's overflow still counts.
                ovf <= of | (ovf & ~clr_m);
            end
        end
    end

endmodule

// File: doc/dsp_mac_pipe.md
Name: dsp_mac_pipe

Overview:
- Parametrised, behavioural successor to the fixed-configuration DSP48E1 wrapper: a signed multiply-accumulate pipeline with configurable operand/result widths and input/multiplier register depth.
- Adds a valid handshake, a per-sample op select (multiply, add C, accumulate, subtract), an accumulator clear and an overflow flag.
- Sits between the PS-facing AXI-lite register block and result readback on the Zynq compute datapath.
- Synthesises to fabric or DSP inference; no primitive instantiation.

Parameters:
- A_W, 30, signed A operand width (2..30)
- B_W, 18, signed B operand width (2..18)
- P_W, 48, result/accumulator width; must be >= A_W+B_W (elaboration error otherwise)
- IN_REGS, 1, input register stages on A/B/C/op/clr (1 or 2)
- MREG, 0, product register stage after the multiplier (0 or 1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  sample valid; operands sampled only when high
- a  in  A_W  signed operand A
- b  in  B_W  signed operand B
- c  in  P_W  signed addend C
- op  in  2  0: P=A*B; 1: P=A*B+C; 2: P=P_acc+A*B; 3: P=C-A*B
- acc_clr  in  1  with op=2: treat P_acc as 0 for this sample
- out_valid  out  1  P holds a new result this cycle
- p  out  P_W  signed result
- ovf  out  1  sticky overflow since reset or last acc_clr

Behaviour:
- Reset (async assert, sync release): all pipeline registers 0; out_valid=0, p=0, ovf=0.
- Latency: L = IN_REGS + MREG + 1 cycles from in_valid to out_valid. The valid bit travels down a shift register alongside the data.
- Pipeline is always enabled; no back-pressure. One result per valid input, order preserved.
- Gaps in in_valid:
  - Bubbles propagate with valid=0.
  - p and the accumulator hold their value on bubble cycles; only valid samples update them.
- Arithmetic:
  - Product is A_W+B_W signed, sign-extended to P_W.
  - The sum is computed in P_W+1 bits.
  - Overflow = bit P_W differs from bit P_W-1 of the P_W+1 sum; otherwise the result wraps to P_W.
- Accumulator:
  - p is the accumulator; op 0/1/3 overwrite it, op 2 adds to it.
  - Back-to-back op=2 samples accumulate every cycle, so the feedback path is 1 cycle through the final register.
- acc_clr:
  - With op=2: the result is the product alone, and ovf clears in the same cycle the result is written. It sets again if that same add overflows.
  - With op 0/1/3: clears ovf only.
- ovf: sticky; set at the final stage on any valid overflowing op.
- Reset mid-stream: all in-flight samples are discarded; no out_valid until new input arrives.
- Extremes:
  - (-2^(A_W-1)) * (-2^(B_W-1)) must be exact.
  - The product itself never overflows when P_W >= A_W+B_W; only the add can.

Optional Feature:
- Macro DSP_MAC_SAT_EN.
- Defined: on overflow, p saturates to +(2^(P_W-1)-1) or -2^(P_W-1) according to the sign of the true (P_W+1-bit) sum; ovf still sets.
- Undefined: two's-complement wrap as above.

Decomposition:
- Shared package dsp_pkg holds:
  - op encoding constants OP_MUL=2'd0, OP_MULADD=2'd1, OP_MACC=2'd2, OP_CSUB=2'd3
  - localparam function for L
  - sat_max/sat_min helper functions
- One sub-module is natural: dsp_delay_line (parametrised width, depth, async-reset shift register). It is reused for the input stages and the valid pipe.

Test Plan:
- Reset and latency (A_W=30, B_W=18, P_W=48, IN_REGS=1, MREG=0, so L=2): op=0, a=3, b=5, one valid -> out_valid exactly 2 cycles later, p=15, then p holds 15.
- op=1: a=-4, b=7, c=0x0000_0009_5514 -> p=0x0000_0009_54F8; op=3 with same inputs -> p=0x0000_0009_5530.
- Accumulate: op=2, acc_clr=1 on the first sample, then 4 back-to-back samples a=2,b=3 (op=2, acc_clr=0) with one bubble inserted -> p steps 6,12,18,24,30; 5 out_valid pulses total; p is unchanged during the bubble.
- Overflow: P_W=48, c=2^47-1, op=1, a=1, b=1:
  - wrap build -> p=-2^47, ovf=1
  - DSP_MAC_SAT_EN build -> p=2^47-1, ovf=1
  - then op=2 with acc_clr=1 -> ovf=0.
- Extreme operands: a=-2^29, b=-2^17, op=0 -> p=2^46, ovf=0. Repeat with IN_REGS=2, MREG=1 -> same p after L=4.
- Async reset mid-stream: assert rst with 2 samples in flight -> out_valid, p and ovf go to 0 immediately; no stale out_valid after release.
